// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit paths:
// frame geometry and the bit-level state encoding.
package uart_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int FRAME_BITS = 11;

    typedef enum logic [2:0] {
        IDLE       = 3'b000,
        START_BIT  = 3'b001,
        DATA_BIT   = 3'b010,
        PARITY_BIT = 3'b011,
        STOP_BIT   = 3'b100
    } uart_state_e;

endpackage

// File: rtl/receiver_sipo.sv
// Serial-in parallel-out shift register; the receive-side twin of the
// transmitter's piso. New bits enter at the MSB so an LSB-first stream lands in order.
module sipo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] parallel_out
);

    logic [WIDTH-1:0] shift_r;

    // Shift register: load one bit at the MSB end on each enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= {WIDTH{1'b0}};
        end else if (shift_en) begin
            shift_r <= {serial_in, shift_r[WIDTH-1:1]};
        end else begin
            shift_r <= shift_r;
        end
    end

    assign parallel_out = shift_r;

endmodule

// File: rtl/receiver.sv
// UART receive path: 2-flop synchronizer, mid-bit sampling FSM and status flags.
// Build option RX_MAJORITY_EN: each bit decision is a 2-of-3 vote over the last three line samples.
module receiver #(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  rx_clk,
    input  logic                  rst_n,
    input  logic                  rx_enable,
    input  logic                  rx_data_in,
    output logic [DATA_WIDTH-1:0] rx_data_out,
    output logic                  done,
    output logic                  busy,
    output logic                  parity_error,
    output logic                  framing_error
);

    import uart_pkg::*;

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

    if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0) || ((DATA_WIDTH + 3) != FRAME_BITS)) begin : g_param_guard
        $error("receiver: OVERSAMPLE must be even and >= 4, frame must be FRAME_BITS long");
    end

    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data);
        return ^data;
    endfunction

    logic                  rx_meta_r;
    logic                  rxs_r;
    logic                  sample_s;
    uart_state_e           state_r;
    uart_state_e           state_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_s;
    logic [BIT_W-1:0]      bit_r;
    logic [BIT_W-1:0]      bit_s;
    logic                  shift_en_s;
    logic                  parity_load_s;
    logic                  frame_done_s;
    logic                  parity_bit_r;
    logic [DATA_WIDTH-1:0] shift_data_s;
    logic [DATA_WIDTH-1:0] rx_data_out_r;
    logic                  done_r;
    logic                  busy_r;
    logic                  parity_error_r;
    logic                  framing_error_r;

    // Two-flop synchronizer for the asynchronous serial line (idles high)
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
        end else begin
            rx_meta_r <= rx_data_in;
            rxs_r     <= rx_meta_r;
        end
    end

`ifdef RX_MAJORITY_EN
    logic rxs_d1_r;
    logic rxs_d2_r;

    // History of the synchronized line for the three-sample vote
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            rxs_d1_r <= 1'b1;
            rxs_d2_r <= 1'b1;
        end else begin
            rxs_d1_r <= rxs_r;
            rxs_d2_r <= rxs_d1_r;
        end
    end

    assign sample_s = (rxs_r & rxs_d1_r) | (rxs_r & rxs_d2_r) | (rxs_d1_r & rxs_d2_r);
`else
    assign sample_s = rxs_r;
`endif

    // Next-state logic; the start detect in IDLE uses the raw synchronized line
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        bit_s         = bit_r;
        shift_en_s    = 1'b0;
        parity_load_s = 1'b0;
        frame_done_s  = 1'b0;
        if (!rx_enable) begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
            bit_s   = {BIT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_s = {CNT_W{1'b0}};
                    bit_s = {BIT_W{1'b0}};
                    if (!rxs_r) begin
                        state_s = START_BIT;
                    end else begin
                        state_s = IDLE;
                    end
                end
                START_BIT: begin
                    if (cnt_r == HALF_LAST) begin
                        cnt_s   = {CNT_W{1'b0}};
                        state_s = sample_s ? IDLE : DATA_BIT;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                DATA_BIT: begin
                    if (cnt_r == FULL_LAST) begin
                        cnt_s      = {CNT_W{1'b0}};
                        shift_en_s = 1'b1;
                        if (bit_r == BIT_LAST) begin
                            bit_s   = {BIT_W{1'b0}};
                            state_s = PARITY_BIT;
                        end else begin
                            bit_s = bit_r + BIT_ONE;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                PARITY_BIT: begin
                    if (cnt_r == FULL_LAST) begin
                        cnt_s         = {CNT_W{1'b0}};
                        parity_load_s = 1'b1;
                        state_s       = STOP_BIT;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                STOP_BIT: begin
                    if (cnt_r == FULL_LAST) begin
                        cnt_s        = {CNT_W{1'b0}};
                        frame_done_s = 1'b1;
                        state_s      = IDLE;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                    bit_s   = {BIT_W{1'b0}};
                end
            endcase
        end
    end

    // State and counter registers
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            bit_r   <= {BIT_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
        end
    end

    sipo #(
        .WIDTH (DATA_WIDTH)
    ) u_sipo (
        .clk          (rx_clk),
        .rst_n        (rst_n),
        .shift_en     (shift_en_s),
        .serial_in    (sample_s),
        .parallel_out (shift_data_s)
    );

    // Received parity bit, compared against the data once the stop bit is taken
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_bit_r <= 1'b0;
        end else if (parity_load_s) begin
            parity_bit_r <= sample_s;
        end else begin
            parity_bit_r <= parity_bit_r;
        end
    end

    // Output registers: results only change on a completed frame
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_out_r   <= {DATA_WIDTH{1'b0}};
            parity_error_r  <= 1'b0;
            framing_error_r <= 1'b0;
            done_r          <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            done_r <= frame_done_s;
            busy_r <= (state_s != IDLE);
            if (frame_done_s) begin
                rx_data_out_r   <= shift_data_s;
                parity_error_r  <= parity_bit_r ^ calc_parity(shift_data_s);
                framing_error_r <= ~sample_s;
            end else begin
                rx_data_out_r   <= rx_data_out_r;
                parity_error_r  <= parity_error_r;
                framing_error_r <= framing_error_r;
            end
        end
    end

    assign rx_data_out   = rx_data_out_r;
    assign done          = done_r;
    assign busy          = busy_r;
    assign parity_error  = parity_error_r;
    assign framing_error = framing_error_r;

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for the UART receiver: stimulus pushes the expected frame
// result, an independent monitor pops and compares on every done pulse.
module tb_receiver;

    localparam int DW = 8;
    localparam int OS = 8;
    localparam int STOP_LAT = 3 + OS / 2 + (DW + 2) * OS;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } exp_t;

    logic          rx_clk;
    logic          rst_n;
    logic          rx_enable;
    logic          rx_data_in;
    logic [DW-1:0] rx_data_out;
    logic          done;
    logic          busy;
    logic          parity_error;
    logic          framing_error;

    int   cyc;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    logic [7:0] last_data;
    logic       last_perr;
    logic       last_ferr;

    receiver #(
        .DATA_WIDTH (DW),
        .OVERSAMPLE (OS)
    ) dut (
        .rx_clk        (rx_clk),
        .rst_n         (rst_n),
        .rx_enable     (rx_enable),
        .rx_data_in    (rx_data_in),
        .rx_data_out   (rx_data_out),
        .done          (done),
        .busy          (busy),
        .parity_error  (parity_error),
        .framing_error (framing_error)
    );

    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    always @(posedge rx_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge rx_clk);
            #1;
        end
    endtask

    task automatic at_cycle(input int n);
        do @(negedge rx_clk); while (cyc < n);
    endtask

    task automatic check_hold(input string tag);
        chk({tag, "_data_hold"}, rx_data_out, last_data);
        chk({tag, "_perr_hold"}, parity_error, last_perr);
        chk({tag, "_ferr_hold"}, framing_error, last_ferr);
    endtask

    // Drive one frame LSB first; expected result derived from the frame rules
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int gap, input bit expect_it);
        exp_t        e;
        logic [10:0] bits;
        e.data = d;
        e.perr = (par != ^d);
        e.ferr = ~stop;
        e.cyc  = cyc + STOP_LAT;
        if (expect_it) exp_q.push_back(e);
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx_data_in = bits[i];
            step(OS);
        end
        rx_data_in = 1'b1;
        step(gap);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge rx_clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d: got done=1 data %0h expected no done", cyc, rx_data_out);
            end else begin
                e = exp_q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("rx_data_out", rx_data_out, e.data);
                chk("parity_error", parity_error, e.perr);
                chk("framing_error", framing_error, e.ferr);
                last_data = e.data;
                last_perr = e.perr;
                last_ferr = e.ferr;
            end
        end
    end

    initial begin
        int c;
        logic [7:0] d;
        logic par;
        logic stop;
        int gap;

        cyc        = 0;
        checks     = 0;
        errors     = 0;
        last_data  = 8'h00;
        last_perr  = 1'b0;
        last_ferr  = 1'b0;
        rst_n      = 1'b1;
        rx_enable  = 1'b0;
        rx_data_in = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_data", rx_data_out, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_perr", parity_error, 0);
        chk("reset_ferr", framing_error, 0);
        step(3);
        rst_n = 1'b1;
        step(2);
        rx_enable = 1'b1;
        step(4);

        // 0xA5 clean frame with busy window checks
        c = cyc;
        fork
            send_frame(8'hA5, 1'b0, 1'b1, 4, 1'b1);
            begin
                at_cycle(c + 2);
                chk("busy_before_T0", busy, 0);
                at_cycle(c + 3);
                chk("busy_at_T0", busy, 1);
                at_cycle(c + STOP_LAT - 1);
                chk("busy_before_stop", busy, 1);
                at_cycle(c + STOP_LAT);
                chk("busy_after_stop", busy, 0);
            end
        join

        send_frame(8'h07, 1'b0, 1'b1, 4, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0, 16, 1'b1);
        send_frame(8'h81, 1'b0, 1'b1, 4, 1'b1);

        // Short glitch: false start returns to idle at T0+4 without done
        c = cyc;
        rx_data_in = 1'b0;
        step(2);
        rx_data_in = 1'b1;
        at_cycle(c + 6);
        chk("glitch_busy_start", busy, 1);
        at_cycle(c + 7);
        chk("glitch_busy_idle", busy, 0);
        step(20);
        check_hold("glitch");

        send_frame(8'h55, 1'b0, 1'b1, 0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b1, 6, 1'b1);

        // Enable dropped mid data bit 3
        c = cyc;
        fork
            send_frame(8'h5A, 1'b0, 1'b1, 8, 1'b0);
            begin
                at_cycle(c + 3 + OS / 2 + 3 * OS + OS / 2);
                rx_enable = 1'b0;
                at_cycle(c + 3 + OS / 2 + 3 * OS + OS / 2 + 1);
                chk("abort_busy", busy, 0);
            end
        join
        check_hold("abort");
        rx_enable = 1'b1;
        step(4);

        // Reset mid-frame clears everything immediately
        c = cyc;
        fork
            send_frame(8'hC3, 1'b0, 1'b1, 4, 1'b0);
            begin
                step(40);
                rst_n = 1'b0;
                #1;
                chk("rst_mid_data", rx_data_out, 0);
                chk("rst_mid_done", done, 0);
                chk("rst_mid_busy", busy, 0);
                chk("rst_mid_perr", parity_error, 0);
                chk("rst_mid_ferr", framing_error, 0);
            end
        join
        rst_n = 1'b1;
        last_data = 8'h00;
        last_perr = 1'b0;
        last_ferr = 1'b0;
        step(4);
        chk("post_reset_busy", busy, 0);

`ifdef RX_MAJORITY_EN
        c = cyc;
        fork
            send_frame(8'hA5, 1'b0, 1'b1, 4, 1'b1);
            begin
                step(28);
                rx_data_in = ~rx_data_in;
                step(1);
                rx_data_in = ~rx_data_in;
            end
        join
`endif

        // Randomized frames: mostly good, some parity and stop-bit errors
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom_range(0, 255));
            par  = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
            stop = ($urandom_range(0, 7) != 0);
            gap  = stop ? $urandom_range(0, 12) : 16;
            send_frame(d, par, stop, gap, 1'b1);
        end

        step(100);
        chk("pending_expectations", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
